// File: rtl/imm_gen_if.sv
// Decode-stage bundle carrying instructions into imm_gen_pipe and decoded immediates out of it.
// Valid/ready rule: a beat transfers at a rising edge exactly when valid & ready; the source
// holds its payload stable while valid & ~ready, and ready never depends on same-cycle valid.
interface imm_gen_if #(parameter int XLEN = 32);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instruction;
    logic [2:0]       imm_src;
    logic [XLEN-1:0]  pc;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_immediate;
    logic [XLEN-1:0]  out_target;
    logic             out_illegal;

    modport master (
        output in_valid, instruction, imm_src, pc, out_ready,
        input  in_ready, out_valid, out_immediate, out_target, out_illegal
    );

    modport slave (
        input  in_valid, instruction, imm_src, pc, out_ready,
        output in_ready, out_valid, out_immediate, out_target, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate decoder with pc+imm precompute, registered behind a two-entry skid buffer.
// The output register is the FIFO head and the skid register holds the second entry.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    imm_gen_if.slave bus
);
    localparam int SHAMT_W = $clog2(XLEN);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift_f3;
    logic [XLEN-1:0] imm_raw;
    logic            illegal_raw;
    logic [XLEN-1:0] target_raw;

    logic            skid_valid;
    logic [XLEN-1:0] skid_immediate;
    logic [XLEN-1:0] skid_target;
    logic            skid_illegal;

    logic            accept;
    logic            drain;

    assign opcode      = bus.instruction[6:0];
    assign funct3      = bus.instruction[14:12];
    assign is_shift_f3 = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        imm_raw     = '0;
        illegal_raw = 1'b0;
        case (bus.imm_src)
            3'b000: begin
                // Shift immediates carry funct7 in the upper bits, so only shamt is kept.
                if (opcode == 7'b0010011 && is_shift_f3)
                    imm_raw = XLEN'(bus.instruction[19+SHAMT_W:20]);
                else if (XLEN == 64 && opcode == 7'b0011011 && is_shift_f3)
                    imm_raw = XLEN'(bus.instruction[24:20]);
                else
                    imm_raw = XLEN'($signed(bus.instruction[31:20]));
            end
            3'b001: imm_raw = XLEN'($signed({bus.instruction[31:25], bus.instruction[11:7]}));
            3'b010: imm_raw = XLEN'($signed({bus.instruction[31], bus.instruction[7],
                                              bus.instruction[30:25], bus.instruction[11:8], 1'b0}));
            3'b011: imm_raw = XLEN'($signed({bus.instruction[31], bus.instruction[19:12],
                                              bus.instruction[20], bus.instruction[30:21], 1'b0}));
            3'b100: imm_raw = XLEN'($signed({bus.instruction[31:12], 12'b0}));
            3'b101: imm_raw = XLEN'(bus.instruction[19:15]);
            default: illegal_raw = 1'b1;
        endcase
    end

    assign target_raw = bus.pc + imm_raw;

    // in_ready comes straight from a flop so out_ready never reaches the upstream stage.
    assign bus.in_ready = ~skid_valid;
    assign accept       = bus.in_valid & ~skid_valid;
    assign drain        = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid     <= 1'b0;
            bus.out_immediate <= '0;
            bus.out_target    <= '0;
            bus.out_illegal   <= 1'b0;
            skid_valid        <= 1'b0;
            skid_immediate    <= '0;
            skid_target       <= '0;
            skid_illegal      <= 1'b0;
        end else if (flush) begin
            bus.out_valid <= 1'b0;
            skid_valid    <= 1'b0;
        end else if (!bus.out_valid || drain) begin
            if (skid_valid) begin
                bus.out_valid     <= 1'b1;
                bus.out_immediate <= skid_immediate;
                bus.out_target    <= skid_target;
                bus.out_illegal   <= skid_illegal;
                skid_valid        <= 1'b0;
            end else if (accept) begin
                bus.out_valid     <= 1'b1;
                bus.out_immediate <= imm_raw;
                bus.out_target    <= target_raw;
                bus.out_illegal   <= illegal_raw;
            end else begin
                bus.out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid     <= 1'b1;
            skid_immediate <= imm_raw;
            skid_target    <= target_raw;
            skid_illegal   <= illegal_raw;
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives an XLEN=32 and an XLEN=64 instance in lockstep and checks both against a FIFO-level
// reference model that computes immediates as signed integer offsets.
module tb_imm_gen_pipe;
    typedef struct packed {
        logic        ill;
        logic [63:0] imm;
        logic [63:0] tgt;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  src;
    logic [63:0] pc64;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    ent_t exp_q32[$];
    ent_t exp_q64[$];

    imm_gen_if #(.XLEN(32)) b32 ();
    imm_gen_if #(.XLEN(64)) b64 ();

    assign b32.in_valid    = in_valid;
    assign b32.instruction = instr;
    assign b32.imm_src     = src;
    assign b32.pc          = pc64[31:0];
    assign b32.out_ready   = out_ready;
    assign b64.in_valid    = in_valid;
    assign b64.instruction = instr;
    assign b64.imm_src     = src;
    assign b64.pc          = pc64;
    assign b64.out_ready   = out_ready;

    imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32.slave));
    imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Immediate as a signed offset per format, then truncated to the datapath width.
    function automatic ent_t ref_ent(input int xlen, input logic [31:0] ins,
                                     input logic [2:0] s, input logic [63:0] p);
        ent_t        e;
        longint      x;
        logic [63:0] mask;
        logic [6:0]  op;
        logic [2:0]  f3;
        bit          sh;
        op   = ins[6:0];
        f3   = ins[14:12];
        sh   = (f3 == 3'd1) || (f3 == 3'd5);
        mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        x    = 0;
        e.ill = 1'b0;
        case (s)
            3'd0: begin
                if (op == 7'h13 && sh)                    x = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
                else if (xlen == 64 && op == 7'h1B && sh) x = longint'(ins[24:20]);
                else begin
                    x = longint'(ins[31:20]);
                    if (x >= 2048) x -= 4096;
                end
            end
            3'd1: begin
                x = longint'({ins[31:25], ins[11:7]});
                if (x >= 2048) x -= 4096;
            end
            3'd2: begin
                x = 2 * longint'({ins[31], ins[7], ins[30:25], ins[11:8]});
                if (x >= 4096) x -= 8192;
            end
            3'd3: begin
                x = 2 * longint'({ins[31], ins[19:12], ins[20], ins[30:21]});
                if (x >= 1048576) x -= 2097152;
            end
            3'd4: begin
                x = longint'(ins[31:12]) * 4096;
                if (x >= 64'h8000_0000) x -= 64'h1_0000_0000;
            end
            3'd5: x = longint'(ins[19:15]);
            default: e.ill = 1'b1;
        endcase
        e.imm = 64'(x) & mask;
        e.tgt = (p + 64'(x)) & mask;
        return e;
    endfunction

    task automatic check_outputs();
        chk("valid32", 64'(b32.out_valid), 64'(exp_q32.size() > 0));
        chk("ready32", 64'(b32.in_ready), 64'(exp_q32.size() < 2));
        chk("valid64", 64'(b64.out_valid), 64'(exp_q64.size() > 0));
        chk("ready64", 64'(b64.in_ready), 64'(exp_q64.size() < 2));
        if (exp_q32.size() > 0) begin
            chk("imm32", 64'(b32.out_immediate), exp_q32[0].imm);
            chk("tgt32", 64'(b32.out_target), exp_q32[0].tgt);
            chk("ill32", 64'(b32.out_illegal), 64'(exp_q32[0].ill));
        end
        if (exp_q64.size() > 0) begin
            chk("imm64", b64.out_immediate, exp_q64[0].imm);
            chk("tgt64", b64.out_target, exp_q64[0].tgt);
            chk("ill64", 64'(b64.out_illegal), 64'(exp_q64[0].ill));
        end
    endtask

    // Called just after a falling edge with inputs settled; advances one clock.
    task automatic cycle();
        bit acc;
        bit pop;
        if (flush) begin
            exp_q32.delete();
            exp_q64.delete();
        end else begin
            acc = in_valid && (exp_q32.size() < 2);
            pop = (exp_q32.size() > 0) && out_ready;
            if (pop) begin
                void'(exp_q32.pop_front());
                void'(exp_q64.pop_front());
            end
            if (acc) begin
                exp_q32.push_back(ref_ent(32, instr, src, pc64));
                exp_q64.push_back(ref_ent(64, instr, src, pc64));
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] s,
                         input logic [63:0] p);
        in_valid = v;
        instr    = ins;
        src      = s;
        pc64     = p;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 32'hFFF0_0093, 3'd0, 64'h100);
        repeat (2) @(negedge clk);
        chk("rst_valid32", 64'(b32.out_valid), 64'd0);
        chk("rst_imm32", 64'(b32.out_immediate), 64'd0);
        chk("rst_tgt32", 64'(b32.out_target), 64'd0);
        chk("rst_ill32", 64'(b32.out_illegal), 64'd0);
        chk("rst_ready32", 64'(b32.in_ready), 64'd1);
        chk("rst_valid64", 64'(b64.out_valid), 64'd0);
        chk("rst_ready64", 64'(b64.in_ready), 64'd1);
        rst = 1'b0;
        out_ready = 1'b1;

        drive(1'b1, 32'hFFF0_0093, 3'd0, 64'h100);
        cycle();
        chk("addi_valid", 64'(b32.out_valid), 64'd1);
        chk("addi_imm", 64'(b32.out_immediate), 64'hFFFF_FFFF);
        chk("addi_tgt", 64'(b32.out_target), 64'h0000_00FF);
        drive(1'b1, 32'h03F0_1093, 3'd0, 64'h0);
        cycle();
        chk("slli_imm64", b64.out_immediate, 64'h3F);
        drive(1'b1, 32'h01F0_109B, 3'd0, 64'h0);
        cycle();
        chk("slliw_imm64", b64.out_immediate, 64'h1F);
        drive(1'b1, 32'h4070_D093, 3'd0, 64'h0);
        cycle();
        chk("srai_imm64", b64.out_immediate, 64'h7);
        drive(1'b1, 32'hFE00_0EE3, 3'd2, 64'h2000);
        cycle();
        chk("beq_imm", 64'(b32.out_immediate), 64'hFFFF_FFFC);
        chk("beq_tgt", 64'(b32.out_target), 64'h0000_1FFC);
        drive(1'b1, 32'h8000_00B7, 3'd4, 64'h0);
        cycle();
        chk("lui_imm64", b64.out_immediate, 64'hFFFF_FFFF_8000_0000);
        drive(1'b1, 32'h3401_D073, 3'd5, 64'h0);
        cycle();
        chk("zimm_imm", 64'(b32.out_immediate), 64'h3);
        drive(1'b1, 32'hFFFF_FFFF, 3'd7, 64'h40);
        cycle();
        chk("illegal_flag", 64'(b32.out_illegal), 64'd1);
        chk("illegal_imm", 64'(b32.out_immediate), 64'd0);
        drive(1'b1, 32'h0100_006F, 3'd3, 64'hFFFF_FFF8);
        cycle();
        chk("jal_wrap_tgt", 64'(b32.out_target), 64'h8);
        drive(1'b0, 32'h0, 3'd0, 64'h0);
        cycle();

        // Backpressure: A, B accepted, C held upstream, then drained in order.
        out_ready = 1'b0;
        drive(1'b1, 32'h0010_0093, 3'd0, 64'h10);
        cycle();
        drive(1'b1, 32'h0020_0093, 3'd0, 64'h20);
        cycle();
        chk("bp_ready_low", 64'(b32.in_ready), 64'd0);
        drive(1'b1, 32'h0030_0093, 3'd0, 64'h30);
        cycle();
        chk("bp_head_a", 64'(b32.out_immediate), 64'h1);
        out_ready = 1'b1;
        repeat (3) cycle();
        drive(1'b0, 32'h0, 3'd0, 64'h0);
        repeat (2) cycle();

        // Flush with both entries full and a new instruction presented.
        out_ready = 1'b0;
        drive(1'b1, 32'h0040_0093, 3'd0, 64'h0);
        cycle();
        drive(1'b1, 32'h0050_0093, 3'd0, 64'h0);
        cycle();
        flush = 1'b1;
        drive(1'b1, 32'h0060_0093, 3'd0, 64'h0);
        cycle();
        chk("flush_valid", 64'(b32.out_valid), 64'd0);
        chk("flush_ready", 64'(b32.in_ready), 64'd1);
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 3'd0, 64'h0);
        cycle();
        chk("flush_no_ghost", 64'(b32.out_valid), 64'd0);

        // Asynchronous reset while an entry is held at the output.
        out_ready = 1'b0;
        drive(1'b1, 32'h0070_0093, 3'd0, 64'h0);
        cycle();
        rst = 1'b1;
        #1;
        chk("arst_valid32", 64'(b32.out_valid), 64'd0);
        chk("arst_imm32", 64'(b32.out_immediate), 64'd0);
        chk("arst_valid64", 64'(b64.out_valid), 64'd0);
        exp_q32.delete();
        exp_q64.delete();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 64'h0);
        cycle();

        // Randomised traffic with shift encodings biased in.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                r[6:0]   = ($urandom_range(0, 1) == 0) ? 7'h13 : 7'h1B;
                r[14:12] = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5;
            end
            drive(1'($urandom_range(0, 3) != 0), r, 3'($urandom_range(0, 7)),
                  {$urandom, $urandom});
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            cycle();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 3'd0, 64'h0);
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
